// File: rtl/cam_pkg.sv
// cam_pkg: shared widths, default frame geometry and helpers for the cam_* pipeline stages.
package cam_pkg;
    localparam int COORD_W      = 10;
    localparam int CNT_W        = 19;
    localparam int H_ACTIVE_DEF = 480;
    localparam int V_ACTIVE_DEF = 272;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    typedef struct packed {
        coord_t x_min;
        coord_t x_max;
        coord_t y_min;
        coord_t y_max;
    } box_t;

    // Empty-accumulator value: min fields at all-ones so the first pixel always wins.
    localparam box_t BOX_CLR = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0};

    function automatic coord_t sat_inc(input coord_t v, input coord_t lim);
        return (v == lim) ? v : coord_t'(v + 1'b1);
    endfunction
endpackage

// File: rtl/cam_pos_cnt.sv
// cam_pos_cnt: saturating pixel x/y position counters and vsync rising-edge detect.
module cam_pos_cnt
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   de_i,
    input  logic   vs_i,
    output coord_t x_o,
    output coord_t y_o,
    output logic   vs_rise_o
);
    localparam coord_t X_LIM = coord_t'(H_ACTIVE - 1);
    localparam coord_t Y_LIM = coord_t'(V_ACTIVE - 1);

    coord_t x_q, x_d, y_q, y_d;
    logic   de_q, vs_q;

    assign vs_rise_o = vs_i & ~vs_q;
    assign x_o       = x_q;
    assign y_o       = y_q;

    // x only ever leaves 0 while de is high, so holding it at 0 when de is low is the falling-edge clear.
    always_comb begin
        x_d = de_i ? sat_inc(x_q, X_LIM) : '0;
        y_d = vs_rise_o ? '0 : (de_q & ~de_i) ? sat_inc(y_q, Y_LIM) : y_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            de_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            de_q <= de_i;
            vs_q <= vs_i;
        end
    end
endmodule

// File: rtl/cam_bbox.sv
// cam_bbox: per-frame bounding box of a binary mask, published at vsync, with a
// one-cycle pass-through that overlays the previous valid box border.
module cam_bbox
    import cam_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int MIN_PIXELS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_data,
    input  logic               in_de,
    input  logic               in_hs,
    input  logic               in_vs,
    output logic               out_data,
    output logic               out_de,
    output logic               out_hs,
    output logic               out_vs,
    output logic               out_edge,
    output logic [COORD_W-1:0] box_x_min,
    output logic [COORD_W-1:0] box_x_max,
    output logic [COORD_W-1:0] box_y_min,
    output logic [COORD_W-1:0] box_y_max,
    output logic [CNT_W-1:0]   pix_count,
    output logic               box_valid,
    output logic               box_update
);
    localparam cnt_t MIN_CNT = cnt_t'(MIN_PIXELS);

    coord_t     x, y;
    logic       vs_rise, hit, on_x, on_y;
    box_t       run_q, run_d, box_q, box_d;
    cnt_t       cnt_q, cnt_d, pix_q, pix_d;
    logic       armed_q, armed_d, valid_q, valid_d, upd_q, upd_d, edge_q, edge_d;
    logic [3:0] pass_q;

    cam_pos_cnt #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_pos (
        .clk      (clk),
        .rst      (rst),
        .de_i     (in_de),
        .vs_i     (in_vs),
        .x_o      (x),
        .y_o      (y),
        .vs_rise_o(vs_rise)
    );

    assign hit  = in_de & in_data & ~vs_rise;
    assign on_x = (x == box_q.x_min || x == box_q.x_max) && y >= box_q.y_min && y <= box_q.y_max;
    assign on_y = (y == box_q.y_min || y == box_q.y_max) && x >= box_q.x_min && x <= box_q.x_max;

    always_comb begin
        run_d   = run_q;
        cnt_d   = cnt_q;
        box_d   = box_q;
        pix_d   = pix_q;
        valid_d = valid_q;
        armed_d = armed_q;
        upd_d   = 1'b0;
        edge_d  = in_de & valid_q & (on_x | on_y);
        if (vs_rise) begin
            run_d   = BOX_CLR;
            cnt_d   = '0;
            armed_d = 1'b1;
            if (armed_q) begin
                box_d   = (cnt_q == '0) ? '0 : run_q;
                pix_d   = cnt_q;
                valid_d = cnt_q >= MIN_CNT;
                upd_d   = 1'b1;
            end
        end else if (hit) begin
            run_d.x_min = (x < run_q.x_min) ? x : run_q.x_min;
            run_d.x_max = (x > run_q.x_max) ? x : run_q.x_max;
            run_d.y_min = (y < run_q.y_min) ? y : run_q.y_min;
            run_d.y_max = (y > run_q.y_max) ? y : run_q.y_max;
            cnt_d       = &cnt_q ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q   <= BOX_CLR;
            cnt_q   <= '0;
            box_q   <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            armed_q <= 1'b0;
            upd_q   <= 1'b0;
            edge_q  <= 1'b0;
            pass_q  <= '0;
        end else begin
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            box_q   <= box_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
            armed_q <= armed_d;
            upd_q   <= upd_d;
            edge_q  <= edge_d;
            pass_q  <= {in_data, in_de, in_hs, in_vs};
        end
    end

    assign {out_data, out_de, out_hs, out_vs} = pass_q;
    assign out_edge   = edge_q;
    assign box_x_min  = box_q.x_min;
    assign box_x_max  = box_q.x_max;
    assign box_y_min  = box_q.y_min;
    assign box_y_max  = box_q.y_max;
    assign pix_count  = pix_q;
    assign box_valid  = valid_q;
    assign box_update = upd_q;
endmodule

// File: tb/tb_cam_bbox.sv
// tb_cam_bbox: scoreboard bench for cam_bbox; two instances (MIN_PIXELS 16 and 1) share one stream.
module tb_cam_bbox;
    localparam int H = 128;
    localparam int V = 64;

    logic clk = 0, rst = 1, in_data = 0, in_de = 0, in_hs = 0, in_vs = 0;
    logic a_data, a_de, a_hs, a_vs, a_edge, a_valid, a_upd;
    logic b_data, b_de, b_hs, b_vs, b_edge, b_valid, b_upd;
    logic [9:0]  a_xmin, a_xmax, a_ymin, a_ymax, b_xmin, b_xmax, b_ymin, b_ymax;
    logic [18:0] a_cnt, b_cnt;

    cam_bbox #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(16)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
        .out_data(a_data), .out_de(a_de), .out_hs(a_hs), .out_vs(a_vs), .out_edge(a_edge),
        .box_x_min(a_xmin), .box_x_max(a_xmax), .box_y_min(a_ymin), .box_y_max(a_ymax),
        .pix_count(a_cnt), .box_valid(a_valid), .box_update(a_upd)
    );

    cam_bbox #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(1)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
        .out_data(b_data), .out_de(b_de), .out_hs(b_hs), .out_vs(b_vs), .out_edge(b_edge),
        .box_x_min(b_xmin), .box_x_max(b_xmax), .box_y_min(b_ymin), .box_y_max(b_ymax),
        .pix_count(b_cnt), .box_valid(b_valid), .box_update(b_upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int xmin, xmax, ymin, ymax, cnt;
        bit va, vb;
        int due;
    } pub_t;

    pub_t q[$];
    pub_t pe;
    int checks = 0, fails = 0, cyc = 0, pubs = 0;
    int mxmin = 1023, mxmax = 0, mymin = 1023, mymax = 0, mcnt = 0;
    bit marmed = 0, mvs_q = 0;
    int cur_x = 0, cur_y = 0;
    int exmin = 0, exmax = 0, eymin = 0, eymax = 0;
    bit evalid = 0;
    logic p_rst = 1, p_d = 0, p_de = 0, p_hs = 0, p_vs = 0;
    int p_x = 0, p_y = 0, edge_cnt = 0;
    logic [3:0] exp_pass;
    bit e, eu;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_pass = p_rst ? 4'b0 : {p_d, p_de, p_hs, p_vs};
        chk("pass_a", {a_data, a_de, a_hs, a_vs}, exp_pass);
        chk("pass_b", {b_data, b_de, b_hs, b_vs}, exp_pass);
        e = !p_rst && p_de && evalid &&
            (((p_x == exmin || p_x == exmax) && p_y >= eymin && p_y <= eymax) ||
             ((p_y == eymin || p_y == eymax) && p_x >= exmin && p_x <= exmax));
        chk("edge", a_edge, e);
        edge_cnt += int'(a_edge);
        eu = q.size() > 0 && q[0].due == cyc;
        chk("upd_a", a_upd, eu);
        chk("upd_b", b_upd, eu);
        if (eu) begin
            pe = q.pop_front();
            pubs++;
            chk("xmin", a_xmin, pe.xmin);
            chk("xmax", a_xmax, pe.xmax);
            chk("ymin", a_ymin, pe.ymin);
            chk("ymax", a_ymax, pe.ymax);
            chk("cnt", a_cnt, pe.cnt);
            chk("valid_a", a_valid, pe.va);
            chk("xmin_b", b_xmin, pe.xmin);
            chk("ymax_b", b_ymax, pe.ymax);
            chk("cnt_b", b_cnt, pe.cnt);
            chk("valid_b", b_valid, pe.vb);
            {evalid, exmin, exmax, eymin, eymax} = {pe.va, pe.xmin, pe.xmax, pe.ymin, pe.ymax};
        end
        {p_rst, p_d, p_de, p_hs, p_vs, p_x, p_y} = {rst, in_data, in_de, in_hs, in_vs, cur_x, cur_y};
    end

    function automatic bit pat(input int kind, input int x, input int y);
        case (kind)
            1:       return x == 10 && y == 20;
            2:       return x >= 100 && x <= 104 && y >= 50 && y <= 53;
            3:       return y == 5 && x >= 130 && x <= 139;
            default: return 0;
        endcase
    endfunction

    task automatic clr_model();
        {mxmin, mxmax, mymin, mymax, mcnt} = {32'd1023, 32'd0, 32'd1023, 32'd0, 32'd0};
    endtask

    task automatic step(input logic d, input logic de, input logic hs, input logic vs, input int x, input int y);
        pub_t p;
        @(posedge clk);
        #1;
        {in_data, in_de, in_hs, in_vs} = {d, de, hs, vs};
        cur_x = x;
        cur_y = y;
        if (vs && !mvs_q) begin
            if (marmed) begin
                p.xmin = mcnt == 0 ? 0 : mxmin;
                p.xmax = mcnt == 0 ? 0 : mxmax;
                p.ymin = mcnt == 0 ? 0 : mymin;
                p.ymax = mcnt == 0 ? 0 : mymax;
                p.cnt  = mcnt;
                p.va   = mcnt >= 16;
                p.vb   = mcnt >= 1;
                p.due  = cyc + 1;
                q.push_back(p);
            end
            clr_model();
            marmed = 1;
        end else if (de && d) begin
            if (x < mxmin) mxmin = x;
            if (x > mxmax) mxmax = x;
            if (y < mymin) mymin = y;
            if (y > mymax) mymax = y;
            mcnt++;
        end
        mvs_q = vs;
    endtask

    task automatic frame(input int kind, input int nl, input int w, input bit vs_pix, input bit do_vs);
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < w; x++) step(pat(kind, x, y), 1, 0, 0, x > H - 1 ? H - 1 : x, y);
            repeat (2) step(0, 0, 1, 0, 0, y + 1);
        end
        if (do_vs) begin
            step(vs_pix, vs_pix, 0, 1, 0, nl);
            repeat (2) step(0, 0, 0, 1, 0, 0);
            repeat (2) step(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic do_rst();
        @(posedge clk);
        #1;
        rst = 1;
        {in_data, in_de, in_hs, in_vs} = 4'b0;
        q.delete();
        clr_model();
        marmed = 0;
        mvs_q  = 0;
        evalid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_xmin", a_xmin, 0);
        chk("rst_ymax", a_ymax, 0);
        chk("rst_upd", a_upd, 0);
        chk("rst_edge", a_edge, 0);
        @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        int e0;
        do_rst();
        frame(1, 22, 12, 0, 1);
        frame(1, 22, 12, 0, 1);
        frame(2, 56, 108, 0, 1);
        e0 = edge_cnt;
        frame(0, 56, 108, 0, 1);
        chk("border_px", edge_cnt - e0, 14);
        frame(3, 56, 140, 1, 1);
        frame(2, 28, 108, 0, 0);
        do_rst();
        frame(2, 56, 108, 0, 1);
        frame(2, 56, 108, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0, 0);
        chk("pubs", pubs, 5);
        chk("q_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end
endmodule
